// File: rtl/pipeline_mem_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Carries the request, address, store data, completion ack and load data.
interface pipeline_mem_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/pipeline_mem.sv
// MEM stage: IDLE/ACCESS FSM issuing loads/stores on the data-memory bus and loading MEM/WB.
// Optional macro MEM_ALIGN_CHECK_EN turns misaligned memory ops into 1-cycle faulting ops.
module pipeline_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        regwrite,
    input  logic        memtoreg,
    input  logic [4:0]  writereg,
    input  logic [31:0] aluout,
    input  logic [31:0] memwritedata,
    output logic        stall,
    pipeline_mem_if.master mem,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_writereg,
    output logic [31:0] wb_result,
    output logic        misalign
);
    localparam int DATA_W = 32;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t state, state_next;

    logic is_mem, bad_align, accept, issue, single, completing;
    logic slot_busy, direct, to_pend;

    logic [DATA_W-1:0] hold_addr_p0;
    logic [DATA_W-1:0] hold_wdata_p0;
    logic              hold_we_p0;
    logic [4:0]        hold_reg_p0;
    logic              hold_rw_p0;
    logic              hold_m2r_p0;

    logic              pend_vld_p0;
    logic [4:0]        pend_reg_p0;
    logic              pend_rw_p0;
    logic [DATA_W-1:0] pend_result_p0;
    logic              pend_mis_p0;

    assign is_mem = memread | memwrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_align = is_mem & (aluout[1:0] != 2'b00);
`else
    assign bad_align = 1'b0;
`endif

    assign accept     = ex_valid & ~stall;
    assign issue      = accept & is_mem & ~bad_align;
    assign single     = accept & ~issue;
    assign completing = (state == ACCESS) & mem.dmem_ack;

    // A 1-cycle op that arrives while MEM/WB is taken this edge is parked for one cycle.
    assign slot_busy = completing | pend_vld_p0;
    assign direct    = single & ~slot_busy;
    assign to_pend   = single & slot_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = ACCESS;
            ACCESS:  if (mem.dmem_ack) state_next = issue ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        if (state == ACCESS) begin
            mem.dmem_req = 1'b1;
            mem.dmem_we  = hold_we_p0;
            stall        = ~mem.dmem_ack;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign mem.dmem_addr = hold_addr_p0;
`else
    assign mem.dmem_addr = {hold_addr_p0[DATA_W-1:2], 2'b00};
`endif
    assign mem.dmem_wdata = hold_wdata_p0;

    // Stage p0: hold registers for the op occupying ACCESS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_addr_p0  <= '0;
            hold_wdata_p0 <= '0;
            hold_we_p0    <= 1'b0;
            hold_reg_p0   <= '0;
            hold_rw_p0    <= 1'b0;
            hold_m2r_p0   <= 1'b0;
        end else if (issue) begin
            hold_addr_p0  <= aluout;
            hold_wdata_p0 <= memwritedata;
            hold_we_p0    <= memwrite;
            hold_reg_p0   <= writereg;
            hold_rw_p0    <= regwrite;
            hold_m2r_p0   <= memtoreg & ~memwrite;
        end
    end

    // Stage p0: parked 1-cycle op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld_p0    <= 1'b0;
            pend_reg_p0    <= '0;
            pend_rw_p0     <= 1'b0;
            pend_result_p0 <= '0;
            pend_mis_p0    <= 1'b0;
        end else begin
            pend_vld_p0 <= to_pend;
            if (to_pend) begin
                pend_reg_p0    <= writereg;
                pend_rw_p0     <= regwrite & ~bad_align;
                pend_result_p0 <= aluout;
                pend_mis_p0    <= bad_align;
            end
        end
    end

    // Stage p1: MEM/WB register, at most one op per edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_writereg <= '0;
            wb_result   <= '0;
            misalign    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            if (completing) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= hold_rw_p0;
                wb_writereg <= hold_reg_p0;
                wb_result   <= hold_m2r_p0 ? mem.dmem_rdata : hold_addr_p0;
            end else if (pend_vld_p0) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= pend_rw_p0;
                wb_writereg <= pend_reg_p0;
                wb_result   <= pend_result_p0;
                misalign    <= pend_mis_p0;
            end else if (direct) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= regwrite & ~bad_align;
                wb_writereg <= writereg;
                wb_result   <= aluout;
                misalign    <= bad_align;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_mem.sv
// Directed self-checking bench for pipeline_mem; one task per scenario.
// Expected values are hand-computed constants.
module tb_pipeline_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, memread, memwrite, regwrite, memtoreg;
    logic [4:0]  writereg;
    logic [31:0] aluout, memwritedata;
    logic        stall;
    logic        wb_valid, wb_regwrite, misalign;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_result;
    int          checks = 0;
    int          errors = 0;

    pipeline_mem_if bus();

    pipeline_mem dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .memread(memread),
        .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg),
        .writereg(writereg), .aluout(aluout), .memwritedata(memwritedata),
        .stall(stall), .mem(bus), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_writereg(wb_writereg), .wb_result(wb_result), .misalign(misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1);
    end

    task automatic set_op(input logic v, input logic mr, input logic mw, input logic rw,
                          input logic m2r, input logic [4:0] wr, input logic [31:0] alu,
                          input logic [31:0] wd);
        ex_valid = v; memread = mr; memwrite = mw; regwrite = rw; memtoreg = m2r;
        writereg = wr; aluout = alu; memwritedata = wd;
    endtask

    task automatic clear_op();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_op();
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        #2 reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.dmem_req); end
        checks++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.dmem_we); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        checks++; if (wb_result !== 32'h0) begin errors++; $display("FAIL reset_wb_result: got %h expected 0", wb_result); end
        checks++; if (bus.dmem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.dmem_addr); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_nonmem();
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h10, 32'h0);
        #1;
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL nonmem_req_pre: got %b expected 0", bus.dmem_req); end
        tick();
        clear_op();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL nonmem_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_result !== 32'h10) begin errors++; $display("FAIL nonmem_result: got %h expected 10", wb_result); end
        checks++; if (wb_writereg !== 5'd5) begin errors++; $display("FAIL nonmem_writereg: got %0d expected 5", wb_writereg); end
        checks++; if (wb_regwrite !== 1'b1) begin errors++; $display("FAIL nonmem_regwrite: got %b expected 1", wb_regwrite); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL nonmem_req: got %b expected 0", bus.dmem_req); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL nonmem_bubble: got %b expected 0", wb_valid); end
    endtask

    task automatic test_load_wait();
        int stall_cnt;
        stall_cnt = 0;
        bus.dmem_ack = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0);
        tick();
        clear_op();
        for (int i = 0; i < 3; i++) begin
            if (stall === 1'b1) stall_cnt++;
            checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL load_req_c%0d: got %b expected 1", i, bus.dmem_req); end
            checks++; if (bus.dmem_addr !== 32'h100) begin errors++; $display("FAIL load_addr_c%0d: got %h expected 100", i, bus.dmem_addr); end
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL load_wb_early_c%0d: got %b expected 0", i, wb_valid); end
            tick();
        end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hDEADBEEF;
        #1;
        if (stall === 1'b1) stall_cnt++;
        checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL load_stall_cycles: got %0d expected 3", stall_cnt); end
        checks++; if (bus.dmem_addr !== 32'h100) begin errors++; $display("FAIL load_addr_ack: got %h expected 100", bus.dmem_addr); end
        tick();
        bus.dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_result !== 32'hDEADBEEF) begin errors++; $display("FAIL load_result: got %h expected deadbeef", wb_result); end
        checks++; if (wb_writereg !== 5'd7) begin errors++; $display("FAIL load_writereg: got %0d expected 7", wb_writereg); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL load_req_after: got %b expected 0", bus.dmem_req); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL load_single_pulse: got %b expected 0", wb_valid); end
    endtask

    // Store then load back-to-back with dmem_ack held high throughout.
    task automatic test_back_to_back();
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hCAFEF00D;
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h200, 32'h1234);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_idle_ack_stall: got %b expected 0", stall); end
        tick();
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h204, 32'h0);
        #1;
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL b2b_req1: got %b expected 1", bus.dmem_req); end
        checks++; if (bus.dmem_we !== 1'b1) begin errors++; $display("FAIL b2b_we1: got %b expected 1", bus.dmem_we); end
        checks++; if (bus.dmem_addr !== 32'h200) begin errors++; $display("FAIL b2b_addr1: got %h expected 200", bus.dmem_addr); end
        checks++; if (bus.dmem_wdata !== 32'h1234) begin errors++; $display("FAIL b2b_wdata1: got %h expected 1234", bus.dmem_wdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall1: got %b expected 0", stall); end
        tick();
        clear_op();
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL b2b_req2: got %b expected 1", bus.dmem_req); end
        checks++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL b2b_we2: got %b expected 0", bus.dmem_we); end
        checks++; if (bus.dmem_addr !== 32'h204) begin errors++; $display("FAIL b2b_addr2: got %h expected 204", bus.dmem_addr); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall2: got %b expected 0", stall); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_store_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_result !== 32'h200) begin errors++; $display("FAIL b2b_store_result: got %h expected 200", wb_result); end
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL b2b_store_regwrite: got %b expected 0", wb_regwrite); end
        tick();
        bus.dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_load_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_result !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_load_result: got %h expected cafef00d", wb_result); end
        checks++; if (wb_writereg !== 5'd9) begin errors++; $display("FAIL b2b_load_writereg: got %0d expected 9", wb_writereg); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL b2b_req_end: got %b expected 0", bus.dmem_req); end
        tick();
    endtask

    // Non-memory op accepted on the completion edge of a load writes back one edge later.
    task automatic test_completion_nonmem();
        bus.dmem_ack = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h300, 32'h0);
        tick();
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h55, 32'h0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cn_stall: got %b expected 1", stall); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL cn_no_accept_in_stall: got %b expected 0", wb_valid); end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h77;
        tick();
        clear_op();
        bus.dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL cn_load_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_result !== 32'h77) begin errors++; $display("FAIL cn_load_result: got %h expected 77", wb_result); end
        checks++; if (wb_writereg !== 5'd3) begin errors++; $display("FAIL cn_load_writereg: got %0d expected 3", wb_writereg); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL cn_idle_req: got %b expected 0", bus.dmem_req); end
        tick();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL cn_alu_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_result !== 32'h55) begin errors++; $display("FAIL cn_alu_result: got %h expected 55", wb_result); end
        checks++; if (wb_writereg !== 5'd4) begin errors++; $display("FAIL cn_alu_writereg: got %0d expected 4", wb_writereg); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL cn_bubble: got %b expected 0", wb_valid); end
    endtask

    task automatic test_reset_abort();
        bus.dmem_ack = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h400, 32'h0);
        tick();
        clear_op();
        tick();
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL abort_req_before: got %b expected 1", bus.dmem_req); end
        reset = 1'b1;
        #1;
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL abort_req_async: got %b expected 0", bus.dmem_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b expected 0", stall); end
        checks++; if (wb_result !== 32'h0) begin errors++; $display("FAIL abort_wb_result: got %h expected 0", wb_result); end
        checks++; if (wb_writereg !== 5'd0) begin errors++; $display("FAIL abort_wb_writereg: got %0d expected 0", wb_writereg); end
        checks++; if (bus.dmem_addr !== 32'h0) begin errors++; $display("FAIL abort_addr: got %h expected 0", bus.dmem_addr); end
        tick();
        reset = 1'b0;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hBAD;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL abort_late_ack_valid: got %b expected 0", wb_valid); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL abort_idle_req: got %b expected 0", bus.dmem_req); end
        bus.dmem_ack = 1'b0;
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL abort_idle_valid: got %b expected 0", wb_valid); end
    endtask

    task automatic test_align();
        bus.dmem_ack = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h102, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        tick();
        clear_op();
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL align_req: got %b expected 0", bus.dmem_req); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL align_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL align_regwrite: got %b expected 0", wb_regwrite); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL align_misalign: got %b expected 1", misalign); end
        tick();
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL align_pulse: got %b expected 0", misalign); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL align_bubble: got %b expected 0", wb_valid); end
`else
        tick();
        clear_op();
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL align_req: got %b expected 1", bus.dmem_req); end
        checks++; if (bus.dmem_addr !== 32'h100) begin errors++; $display("FAIL align_addr: got %h expected 100", bus.dmem_addr); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL align_misalign: got %b expected 0", misalign); end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h11;
        tick();
        bus.dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL align_valid: got %b expected 1", wb_valid); end
        checks++; if (wb_result !== 32'h11) begin errors++; $display("FAIL align_result: got %h expected 11", wb_result); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL align_misalign_wb: got %b expected 0", misalign); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_wait();
        test_back_to_back();
        test_completion_nonmem();
        test_reset_abort();
        test_align();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_mem.md
PIPELINE_MEM -- requirements
Module: pipeline_mem

Interface
REQ-001 Parameters: none; data and address widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 ex_valid  input  1  EX/MEM holds a valid instruction.
REQ-005 memread, memwrite, regwrite, memtoreg  input  1 each  control bits carried from EX.
REQ-006 writereg  input  5  destination register number.
REQ-007 aluout  input  32  ALU result, also the memory byte address.
REQ-008 memwritedata  input  32  store data.
REQ-009 stall  output  1  upstream must hold EX/MEM and not advance.
REQ-010 dmem_req, dmem_we  output  1 each  data-memory request and write enable.
REQ-011 dmem_addr, dmem_wdata  output  32 each  memory address and store data.
REQ-012 dmem_ack  input  1  memory completion, sampled on the clock edge.
REQ-013 dmem_rdata  input  32  load data, valid when dmem_ack=1.
REQ-014 wb_valid, wb_regwrite  output  1 each  MEM/WB valid flag and register write enable.
REQ-015 wb_writereg  output  5  MEM/WB destination register.
REQ-016 wb_result  output  32  MEM/WB result: load data when memtoreg=1, otherwise aluout.
REQ-017 misalign  output  1  one-cycle alignment-fault pulse (see Configuration).

Function
REQ-018 FSM has two states, IDLE and ACCESS; accept = ex_valid & ~stall.
REQ-019 A memory op is memread|memwrite; if both are set, memwrite wins and the read is ignored.
REQ-020 Non-memory op accepted in IDLE: MEM/WB loads at that edge, wb_valid=1 next cycle (latency 1), state stays IDLE.
REQ-021 Memory op accepted: addr, wdata, we, writereg, regwrite and memtoreg are latched into hold registers; state goes to ACCESS.
REQ-022 In ACCESS: dmem_req=1 and dmem_addr/dmem_wdata/dmem_we are driven only from the hold registers; these outputs are held stable until ack.
REQ-023 In IDLE: dmem_req=0 and dmem_we=0.
REQ-024 stall = (state==ACCESS) & ~dmem_ack; stall is combinational and is the only combinational path from dmem_ack.
REQ-025 At an edge with ACCESS & dmem_ack: MEM/WB loads from the hold registers (wb_result = dmem_rdata if memtoreg, else the held address), wb_valid=1.
REQ-026 At the same edge, a new accept is permitted: a memory op re-enters ACCESS (back-to-back, no idle cycle); a non-memory op moves the FSM to IDLE.
REQ-027 If that new op is a non-memory op, its own MEM/WB write occurs at the next edge; MEM/WB holds at most one op per edge.
REQ-028 Any edge that loads no op into MEM/WB sets wb_valid=0 (bubble); wb_valid is never high for two cycles on the same op.
REQ-029 dmem_ack while in IDLE is ignored.
REQ-030 A store passes regwrite through unchanged (normally 0); wb_result = aluout for a store.

Reset
REQ-031 Reset asserted forces state IDLE and clears stall, dmem_req, dmem_we, wb_valid, wb_regwrite and misalign to 0 immediately.
REQ-032 Reset also clears wb_writereg, wb_result, dmem_addr, dmem_wdata and all hold registers to 0 immediately.
REQ-033 Reset during ACCESS aborts the access: no wb_valid is generated for it, and an ack arriving later is ignored.
REQ-034 The first accept is possible at the first rising edge after reset deasserts.

Configuration
REQ-035 Macro MEM_ALIGN_CHECK_EN.
REQ-036 Defined: a memory op with aluout[1:0]!=0 never enters ACCESS and never asserts dmem_req.
REQ-037 Defined: such an op completes in 1 cycle with wb_valid=1, wb_regwrite forced 0 and misalign=1 for that cycle.
REQ-038 Undefined: misalign is tied 0, dmem_addr[1:0] is forced to 00, and all ops are issued.

Verification
REQ-039 Non-memory op (aluout=0x0000_0010, regwrite=1, writereg=5) -> next cycle wb_valid=1, wb_result=0x10, wb_writereg=5, dmem_req never high.
REQ-040 Load at addr 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> stall high for exactly 3 cycles, dmem_addr stable at 0x100, then wb_result=0xDEADBEEF, wb_valid pulses once.
REQ-041 Store 0x1234 to 0x200 followed back-to-back by load from 0x204, each acked in its first ACCESS cycle -> dmem_req high continuously for 2 cycles with dmem_we=1 then 0, no idle cycle between them.
REQ-042 Reset asserted in the second ACCESS cycle of a load, ack delivered afterwards -> dmem_req drops asynchronously, no wb_valid, FSM in IDLE.
REQ-043 With MEM_ALIGN_CHECK_EN, load from 0x102 -> dmem_req stays 0, misalign=1 and wb_valid=1 with wb_regwrite=0 for one cycle; without the macro, dmem_addr=0x100.
REQ-044 Load issued while dmem_ack is held constantly at 1 -> completes in 1 ACCESS cycle; stall never asserts for it.
